// File: rtl/knight_monitor.sv
// Tracks a knight-rider LED sweep: acquires a single lit LED, locks after LOCK_N
// consistent steps, and flags jumps or stalls while locked.
module knight_monitor #(
    parameter int unsigned LOCK_N    = 3,
    parameter int unsigned STALL_MAX = 255
) (
    input  logic       ck,
    input  logic       res,
    input  logic [7:0] led,
    output logic [2:0] pos,
    output logic       dir,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic [7:0] sweep_cnt
);

    localparam int unsigned LED_W   = 8;
    localparam int unsigned POS_W   = 3;
    localparam int unsigned GOOD_W  = 4;
    localparam int unsigned CNT_W   = 8;

    localparam logic [GOOD_W-1:0] LOCK_N_V    = GOOD_W'(LOCK_N);
    localparam logic [CNT_W-1:0]  STALL_MAX_V = CNT_W'(STALL_MAX);
    localparam logic [CNT_W-1:0]  CNT_SAT     = '1;
    localparam logic [POS_W-1:0]  POS_TOP     = '1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ACQ    = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LED_W-1:0]   prev;
    logic [GOOD_W-1:0]  good;
    logic [GOOD_W-1:0]  good_nxt;
    logic [CNT_W-1:0]   stall;
    logic [CNT_W-1:0]   stall_nxt;
    logic [POS_W-1:0]   pos_nxt;
    logic               dir_nxt;
    logic               locked_nxt;
    logic               err_nxt;
    logic [CNT_W-1:0]   err_cnt_nxt;
    logic [CNT_W-1:0]   sweep_cnt_nxt;

    logic               hot;
    logic [POS_W-1:0]   idx;
    logic               change;
    logic               up;
    logic               dn;
    logic               free;
    logic               valid;
    logic               fault;
    logic               sweep_hit;

    // Index of the highest set bit; only meaningful when led is one-hot.
    always_comb begin
        idx = '0;
        for (int i = 0; i < int'(LED_W); i++) begin
            if (led[i]) begin
                idx = POS_W'(i);
            end
        end
    end

    assign hot    = (led != '0) && ((led & (led - LED_W'(1))) == '0);
    assign change = (led != prev);
    assign up     = (pos != POS_TOP) && (idx == POS_W'(pos + POS_W'(1)));
    assign dn     = (pos != '0)      && (idx == POS_W'(pos - POS_W'(1)));

    // Either neighbour is acceptable on the first acquisition step and at the ends,
    // where only one neighbour exists and the direction flips.
    assign free  = ((state == ACQ) && (good == '0)) || (pos == '0) || (pos == POS_TOP);
    assign valid = hot && (free ? (up || dn) : (dir ? up : dn));

    always_ff @(posedge ck) begin
        if (!res) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pos_nxt       = pos;
        dir_nxt       = dir;
        good_nxt      = good;
        stall_nxt     = stall;
        err_nxt       = 1'b0;
        err_cnt_nxt   = err_cnt;
        sweep_cnt_nxt = sweep_cnt;
        fault         = 1'b0;
        sweep_hit     = 1'b0;

        case (state)
            SEARCH: begin
                if (hot) begin
                    state_nxt = ACQ;
                    pos_nxt   = idx;
                    good_nxt  = '0;
                    stall_nxt = '0;
                end
            end
            ACQ: begin
                if (change) begin
                    if (valid) begin
                        pos_nxt  = idx;
                        dir_nxt  = up;
                        good_nxt = good + GOOD_W'(1);
                        if (good_nxt == LOCK_N_V) begin
                            state_nxt = LOCK;
                            stall_nxt = '0;
                        end
                    end else begin
                        state_nxt = SEARCH;
                    end
                end
            end
            LOCK: begin
                if (change) begin
                    if (valid) begin
                        pos_nxt   = idx;
                        dir_nxt   = up;
                        stall_nxt = '0;
                        sweep_hit = (pos == POS_W'(1)) && (idx == '0);
                    end else begin
                        fault = 1'b1;
                    end
                end else begin
                    stall_nxt = stall + CNT_W'(1);
                    if (stall_nxt == STALL_MAX_V) begin
                        fault = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase

        // A fault overrides any coincident sweep completion.
        if (fault) begin
            err_nxt     = 1'b1;
            err_cnt_nxt = (err_cnt == CNT_SAT) ? err_cnt : err_cnt + CNT_W'(1);
            state_nxt   = SEARCH;
            stall_nxt   = '0;
        end else if (sweep_hit) begin
            sweep_cnt_nxt = sweep_cnt + CNT_W'(1);
        end

        locked_nxt = (state_nxt == LOCK);
    end

    always_ff @(posedge ck) begin
        if (!res) begin
            prev      <= '0;
            good      <= '0;
            stall     <= '0;
            pos       <= '0;
            dir       <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            sweep_cnt <= '0;
        end else begin
            prev      <= led;
            good      <= good_nxt;
            stall     <= stall_nxt;
            pos       <= pos_nxt;
            dir       <= dir_nxt;
            locked    <= locked_nxt;
            err       <= err_nxt;
            err_cnt   <= err_cnt_nxt;
            sweep_cnt <= sweep_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_knight_monitor.sv
// Bench for knight_monitor: directed scenarios plus a random walk, all checked
// against a position/step reference model kept here.
module tb_knight_monitor;

    localparam int unsigned LOCK_N    = 3;
    localparam int unsigned STALL_MAX = 4;
    localparam int M_SEARCH = 0;
    localparam int M_ACQ    = 1;
    localparam int M_LOCK   = 2;

    logic       ck  = 1'b0;
    logic       res = 1'b0;
    logic [7:0] led = 8'h00;
    logic [2:0] pos;
    logic       dir;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic [7:0] sweep_cnt;

    knight_monitor #(.LOCK_N(LOCK_N), .STALL_MAX(STALL_MAX)) dut (
        .ck(ck), .res(res), .led(led), .pos(pos), .dir(dir), .locked(locked),
        .err(err), .err_cnt(err_cnt), .sweep_cnt(sweep_cnt)
    );

    always #5 ck = ~ck;

    int n_cmp = 0;
    int n_bad = 0;

    int         m_mode   = M_SEARCH;
    int         m_pos    = 0;
    bit         m_dir    = 1'b0;
    int         m_good   = 0;
    int         m_stall  = 0;
    logic [7:0] m_prev   = 8'h00;
    bit         m_err    = 1'b0;
    int         m_errcnt = 0;
    int         m_sweep  = 0;

    logic [21:0] obs;
    assign obs = {pos, dir, locked, err, err_cnt, sweep_cnt};

    function automatic logic [21:0] exp_vec();
        return {3'(m_pos), m_dir, m_mode == M_LOCK, m_err, 8'(m_errcnt), 8'(m_sweep)};
    endfunction

    function automatic bit step_ok(input int from, input bit d, input bit first, input int to);
        if (to < 0 || to > 7) return 1'b0;
        if (first) return (to == from + 1) || (to == from - 1);
        if (from == 7) return to == 6;
        if (from == 0) return to == 1;
        return to == (d ? from + 1 : from - 1);
    endfunction

    task automatic model_edge(input logic [7:0] v, input logic r);
        int idx;
        bit hot;
        bit fault;
        m_err = 1'b0;
        if (!r) begin
            m_mode = M_SEARCH; m_pos = 0; m_dir = 1'b0; m_good = 0; m_stall = 0;
            m_prev = 8'h00; m_errcnt = 0; m_sweep = 0;
            return;
        end
        hot = ($countones(v) == 1);
        idx = -1;
        for (int i = 0; i < 8; i++) if (v[i]) idx = i;
        fault = 1'b0;
        if (m_mode == M_SEARCH) begin
            if (hot) begin
                m_mode = M_ACQ; m_pos = idx; m_good = 0; m_stall = 0;
            end
        end else if (v == m_prev) begin
            if (m_mode == M_LOCK) begin
                m_stall++;
                if (m_stall >= int'(STALL_MAX)) fault = 1'b1;
            end
        end else if (hot && step_ok(m_pos, m_dir, (m_mode == M_ACQ) && (m_good == 0), idx)) begin
            if (m_mode == M_LOCK && m_pos == 1 && idx == 0) m_sweep = (m_sweep + 1) % 256;
            m_dir = (idx > m_pos);
            m_pos = idx;
            if (m_mode == M_ACQ) begin
                m_good++;
                if (m_good == int'(LOCK_N)) m_mode = M_LOCK;
            end else begin
                m_stall = 0;
            end
        end else if (m_mode == M_LOCK) begin
            fault = 1'b1;
        end else begin
            m_mode = M_SEARCH;
        end
        if (fault) begin
            m_err = 1'b1;
            if (m_errcnt < 255) m_errcnt++;
            m_mode  = M_SEARCH;
            m_stall = 0;
        end
        m_prev = v;
    endtask

    // One clock: drive, let the edge happen, advance the model, settle.
    task automatic cyc(input logic [7:0] v, input logic r);
        led = v;
        res = r;
        @(posedge ck);
        model_edge(v, r);
        #1;
    endtask

    task automatic test_reset();
        cyc(8'h00, 1'b0);
        cyc(8'h00, 1'b0);
        n_cmp++;
        if (obs !== 22'h0) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected %h", obs, 22'h0);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(8'h00, 1'b1);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL idle_zero_model: got %h expected %h", obs, exp_vec());
            end
        end
        n_cmp++;
        if ({locked, err, err_cnt, sweep_cnt} !== 18'h0) begin
            n_bad++;
            $display("FAIL idle_zero: got %h expected %h", {locked, err, err_cnt, sweep_cnt}, 18'h0);
        end
    endtask

    task automatic test_acquire();
        cyc(8'h01, 1'b1);
        cyc(8'h02, 1'b1);
        cyc(8'h04, 1'b1);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL acq_early_lock: got %b expected %b", locked, 1'b0);
        end
        cyc(8'h08, 1'b1);
        n_cmp++;
        if ({pos, dir, locked} !== {3'd3, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL acq_lock: got %h expected %h", {pos, dir, locked}, {3'd3, 1'b1, 1'b1});
        end
    endtask

    task automatic test_sweep();
        logic [7:0] v;
        // Legs: up to 0x80, down to 0x01, up again, down again.
        for (int leg = 0; leg < 4; leg++) begin
            for (int s = 0; s < 7; s++) begin
                int p;
                if (leg == 0 && s > 3) break;
                if (leg == 0)          p = 4 + s;
                else if (leg % 2 == 1) p = 6 - s;
                else                   p = 1 + s;
                v = 8'(1 << p);
                cyc(v, 1'b1);
                n_cmp++;
                if (obs !== exp_vec() || dir !== (leg % 2 == 0)) begin
                    n_bad++;
                    $display("FAIL sweep_step: got %h dir %b expected %h dir %b", obs, dir, exp_vec(), (leg % 2 == 0));
                end
            end
        end
        n_cmp++;
        if ({sweep_cnt, err_cnt, locked} !== {8'd2, 8'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL sweep_count: got %h expected %h", {sweep_cnt, err_cnt, locked}, {8'd2, 8'd0, 1'b1});
        end
    endtask

    task automatic test_jump_error();
        cyc(8'h00, 1'b0);
        cyc(8'h01, 1'b1);
        cyc(8'h02, 1'b1);
        cyc(8'h04, 1'b1);
        cyc(8'h08, 1'b1);
        cyc(8'h20, 1'b1);
        n_cmp++;
        if ({err, locked, err_cnt} !== {1'b1, 1'b0, 8'd1}) begin
            n_bad++;
            $display("FAIL jump_err: got %h expected %h", {err, locked, err_cnt}, {1'b1, 1'b0, 8'd1});
        end
        cyc(8'h20, 1'b1);
        n_cmp++;
        if ({err, locked, pos} !== {1'b0, 1'b0, 3'd5}) begin
            n_bad++;
            $display("FAIL jump_reacq: got %h expected %h", {err, locked, pos}, {1'b0, 1'b0, 3'd5});
        end
        cyc(8'h40, 1'b1);
        cyc(8'h80, 1'b1);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL jump_early_lock: got %b expected %b", locked, 1'b0);
        end
        cyc(8'h40, 1'b1);
        n_cmp++;
        if ({locked, pos, dir} !== {1'b1, 3'd6, 1'b0}) begin
            n_bad++;
            $display("FAIL jump_relock: got %h expected %h", {locked, pos, dir}, {1'b1, 3'd6, 1'b0});
        end
    endtask

    task automatic test_stall();
        cyc(8'h00, 1'b0);
        cyc(8'h01, 1'b1);
        cyc(8'h02, 1'b1);
        cyc(8'h04, 1'b1);
        cyc(8'h08, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(8'h08, 1'b1);
            n_cmp++;
            if ({locked, err} !== 2'b10) begin
                n_bad++;
                $display("FAIL stall_hold: got %b expected %b", {locked, err}, 2'b10);
            end
        end
        cyc(8'h08, 1'b1);
        n_cmp++;
        if ({locked, err, err_cnt} !== {1'b0, 1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL stall_err: got %h expected %h", {locked, err, err_cnt}, {1'b0, 1'b1, 8'd1});
        end
        cyc(8'h08, 1'b1);
        n_cmp++;
        if ({locked, err, pos} !== {1'b0, 1'b0, 3'd3}) begin
            n_bad++;
            $display("FAIL stall_reacq: got %h expected %h", {locked, err, pos}, {1'b0, 1'b0, 3'd3});
        end
        cyc(8'h10, 1'b1);
        cyc(8'h20, 1'b1);
        cyc(8'h40, 1'b1);
        n_cmp++;
        if ({locked, pos, dir} !== {1'b1, 3'd6, 1'b1}) begin
            n_bad++;
            $display("FAIL stall_relock: got %h expected %h", {locked, pos, dir}, {1'b1, 3'd6, 1'b1});
        end
    endtask

    task automatic test_random();
        int w;
        int wd;
        int k;
        logic r;
        logic [7:0] v;
        w  = 6;
        wd = -1;
        for (int n = 0; n < 800; n++) begin
            r = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            k = int'($urandom_range(0, 99));
            if (k < 70) begin
                if (w == 7) wd = -1;
                else if (w == 0) wd = 1;
                w = w + wd;
                v = 8'(1 << w);
            end else if (k < 82) begin
                v = led;
            end else if (k < 92) begin
                v = 8'($urandom);
            end else begin
                w = int'($urandom_range(0, 7));
                v = 8'(1 << w);
            end
            cyc(v, r);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_%0d: led %h got %h expected %h", n, v, obs, exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] seq [5];
        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h04; seq[3] = 8'h08; seq[4] = 8'h80;
        cyc(8'h00, 1'b0);
        for (int n = 0; n < 305; n++) begin
            for (int s = 0; s < 5; s++) begin
                cyc(seq[s], 1'b1);
                n_cmp++;
                if (obs !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL sat_%0d_%0d: got %h expected %h", n, s, obs, exp_vec());
                end
            end
        end
        n_cmp++;
        if ({err, err_cnt} !== {1'b1, 8'd255}) begin
            n_bad++;
            $display("FAIL sat_hold: got %h expected %h", {err, err_cnt}, {1'b1, 8'd255});
        end
        for (int s = 0; s < 4; s++) cyc(seq[s], 1'b1);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_relock: got %b expected %b", locked, 1'b1);
        end
        cyc(8'h10, 1'b0);
        n_cmp++;
        if (obs !== 22'h0) begin
            n_bad++;
            $display("FAIL reset_in_lock: got %h expected %h", obs, 22'h0);
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_sweep();
        test_jump_error();
        test_stall();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
